// File: rtl/fetch_pc_gen_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pc_gen_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEF = '0;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_pc_gen_queue.sv
// fetch_queue: synchronous FIFO of fetch entries with flush; head read straight from storage regs.
module fetch_queue
  import fetch_pc_gen_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          push_i,
  input  fetch_entry_t  push_data_i,
  input  logic          pop_i,
  output fetch_entry_t  head_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);
  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q <= (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (do_pop)
        rd_ptr_q <= (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/fetch_pc_gen.sv
// PC generator / I-cache fetch front end. Branch prediction is used only when FETCH_PRED_EN is defined.
module fetch_pc_gen
  import fetch_pc_gen_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          FQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ic_req_o,
  output logic [31:0] ic_addr_o,
  input  logic        ic_stall_i,
  input  logic [31:0] ic_rdata_i,
  output logic [31:0] pred_addr_o,
  input  logic        pred_hit_i,
  input  logic [31:0] pred_target_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        if_valid_o,
  input  logic        if_ready_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_instr_o,
  output logic        if_pred_taken_o,
  output logic [31:0] if_pred_target_o
);
  localparam int CW = $clog2(FQ_DEPTH + 1);

  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q, pc_d, redir_pc_q, redir_pc_d;
  logic          accept, fq_full, fq_empty;
  logic [CW-1:0] fq_count;
  logic          pred_hit_eff;
  logic [31:0]   pred_tgt_eff;
  fetch_entry_t  push_ent, head;

`ifdef FETCH_PRED_EN
  assign pred_hit_eff = pred_hit_i;
  assign pred_tgt_eff = word_align(pred_target_i);
  assign pred_addr_o  = ic_addr_o;
  logic unused_ok;
  assign unused_ok = ^fq_count;
`else
  assign pred_hit_eff = 1'b0;
  assign pred_tgt_eff = '0;
  assign pred_addr_o  = '0;
  logic unused_ok;
  assign unused_ok = ^{pred_hit_i, pred_target_i, fq_count};
`endif

  assign ic_addr_o = pc_q;
  assign ic_req_o  = ((state_q == S_FETCH) & ~fq_full) | (state_q == S_DISCARD);
  assign accept    = (state_q == S_FETCH) & ic_req_o & ~ic_stall_i & ~redirect_i;

  assign push_ent = '{pc: pc_q, instr: ic_rdata_i, pred_taken: pred_hit_eff,
                      pred_target: pred_tgt_eff};

  fetch_queue #(.DEPTH(FQ_DEPTH)) u_fq (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (redirect_i),
    .push_i      (accept),
    .push_data_i (push_ent),
    .pop_i       (if_valid_o & if_ready_i),
    .head_o      (head),
    .count_o     (fq_count),
    .full_o      (fq_full),
    .empty_o     (fq_empty)
  );

  assign if_valid_o       = ~fq_empty;
  assign if_pc_o          = head.pc;
  assign if_instr_o       = head.instr;
  assign if_pred_taken_o  = head.pred_taken;
  assign if_pred_target_o = head.pred_target;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    redir_pc_d = redir_pc_q;
    if (redirect_i) begin
      // A stalled request must complete at its original address; park the target.
      if (ic_req_o & ic_stall_i) begin
        redir_pc_d = word_align(redirect_pc_i);
        state_d    = S_DISCARD;
      end else begin
        pc_d    = word_align(redirect_pc_i);
        state_d = S_FETCH;
      end
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_FETCH;
        S_FETCH: if (accept) pc_d = pred_hit_eff ? pred_tgt_eff : pc_q + 32'd4;
        S_DISCARD: begin
          if (!ic_stall_i) begin
            pc_d    = redir_pc_q;
            state_d = S_FETCH;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      redir_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      redir_pc_q <= redir_pc_d;
    end
  end
endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen; expectations follow FETCH_PRED_EN when it is defined.
module tb_fetch_pc_gen;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        ic_req_o;
  logic [31:0] ic_addr_o;
  logic        ic_stall_i;
  logic [31:0] ic_rdata_i;
  logic [31:0] pred_addr_o;
  logic        pred_hit_i;
  logic [31:0] pred_target_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        if_valid_o;
  logic        if_ready_i;
  logic [31:0] if_pc_o;
  logic [31:0] if_instr_o;
  logic        if_pred_taken_o;
  logic [31:0] if_pred_target_o;

  int errors = 0;
  int checks = 0;

  fetch_pc_gen #(.RESET_PC(32'h0), .FQ_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .ic_req_o(ic_req_o), .ic_addr_o(ic_addr_o), .ic_stall_i(ic_stall_i),
    .ic_rdata_i(ic_rdata_i), .pred_addr_o(pred_addr_o), .pred_hit_i(pred_hit_i),
    .pred_target_i(pred_target_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .if_valid_o(if_valid_o), .if_ready_i(if_ready_i), .if_pc_o(if_pc_o),
    .if_instr_o(if_instr_o), .if_pred_taken_o(if_pred_taken_o),
    .if_pred_target_o(if_pred_target_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

`ifdef FETCH_PRED_EN
  localparam logic [31:0] P1 = 32'h100;
  localparam logic        PT = 1'b1;
  localparam logic [31:0] PTG = 32'h100;
  localparam logic [31:0] PA8 = 32'h8;
`else
  localparam logic [31:0] P1 = 32'hC;
  localparam logic        PT = 1'b0;
  localparam logic [31:0] PTG = 32'h0;
  localparam logic [31:0] PA8 = 32'h0;
`endif

  initial begin
    int acc;
    rst_n = 1'b0; ic_stall_i = 1'b0; ic_rdata_i = '0; pred_hit_i = 1'b0;
    pred_target_i = '0; redirect_i = 1'b0; redirect_pc_i = '0; if_ready_i = 1'b1;
    step(); step();
    chk("rst_req", 32'(ic_req_o), 32'd0);
    chk("rst_valid", 32'(if_valid_o), 32'd0);
    chk("rst_pc", if_pc_o, 32'h0);
    chk("rst_instr", if_instr_o, 32'h0);
    chk("rst_ptaken", 32'(if_pred_taken_o), 32'd0);
    chk("rst_ptgt", if_pred_target_o, 32'h0);

    // Streaming with decode always ready.
    rst_n = 1'b1;
    step();
    chk("idle_to_fetch_req", 32'(ic_req_o), 32'd1);
    chk("addr0", ic_addr_o, 32'h0);
    chk("no_valid_yet", 32'(if_valid_o), 32'd0);
    ic_rdata_i = 32'h1111_0000;
    step();
    chk("addr4", ic_addr_o, 32'h4);
    chk("head_valid0", 32'(if_valid_o), 32'd1);
    chk("head_pc0", if_pc_o, 32'h0);
    chk("head_instr0", if_instr_o, 32'h1111_0000);
    ic_rdata_i = 32'h1111_0004;
    step();
    chk("addr8", ic_addr_o, 32'h8);
    chk("head_pc4", if_pc_o, 32'h4);
    chk("head_instr4", if_instr_o, 32'h1111_0004);

    // Predicted-taken fetch at 0x8.
    pred_hit_i = 1'b1; pred_target_i = 32'h103; ic_rdata_i = 32'h1111_0008;
    chk("pred_addr", pred_addr_o, PA8);
    step();
    pred_hit_i = 1'b0; pred_target_i = '0;
    chk("addr_after_pred", ic_addr_o, P1);
    chk("head_pc8", if_pc_o, 32'h8);
    chk("head_ptaken", 32'(if_pred_taken_o), 32'(PT));
    chk("head_ptgt", if_pred_target_o, PTG);

    // Drain under stall, then back-pressure with depth 2.
    ic_stall_i = 1'b1;
    step();
    chk("drained", 32'(if_valid_o), 32'd0);
    chk("stall_hold_addr", ic_addr_o, P1);
    ic_stall_i = 1'b0; if_ready_i = 1'b0; ic_rdata_i = 32'h2222_0000;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      if (ic_req_o && !ic_stall_i) acc++;
      step();
    end
    chk("bp_accepts", 32'(acc), 32'd2);
    chk("bp_req_low", 32'(ic_req_o), 32'd0);
    chk("bp_head_pc", if_pc_o, P1);
    chk("bp_addr", ic_addr_o, P1 + 32'd8);
    if_ready_i = 1'b1;
    step();
    chk("bp_req_back", 32'(ic_req_o), 32'd1);
    chk("bp_head_next", if_pc_o, P1 + 32'd4);

    // Plain redirect to 0x40 flushes the queue.
    redirect_i = 1'b1; redirect_pc_i = 32'h40;
    step();
    chk("redir_flush", 32'(if_valid_o), 32'd0);
    chk("redir_addr40", ic_addr_o, 32'h40);

    // Redirect while stalled: address holds, stale data dropped.
    ic_stall_i = 1'b1; redirect_pc_i = 32'h202;
    step();
    redirect_i = 1'b0;
    chk("disc_req", 32'(ic_req_o), 32'd1);
    chk("disc_addr_hold", ic_addr_o, 32'h40);
    step(); step();
    chk("disc_addr_hold2", ic_addr_o, 32'h40);
    ic_stall_i = 1'b0; ic_rdata_i = 32'hBAD0_BAD0;
    step();
    chk("disc_resume", ic_addr_o, 32'h200);
    chk("disc_dropped", 32'(if_valid_o), 32'd0);

    // Two redirects inside one discard window: last wins.
    ic_stall_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h300;
    step();
    redirect_pc_i = 32'h380;
    step();
    redirect_i = 1'b0;
    chk("disc2_hold", ic_addr_o, 32'h200);
    ic_stall_i = 1'b0;
    step();
    chk("disc2_resume", ic_addr_o, 32'h380);
    chk("disc2_empty", 32'(if_valid_o), 32'd0);

    // PC wrap at top of address space.
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    step();
    redirect_i = 1'b0;
    chk("wrap_top", ic_addr_o, 32'hFFFF_FFFC);
    ic_rdata_i = 32'h0000_0077;
    step();
    chk("wrap_addr0", ic_addr_o, 32'h0);
    chk("wrap_head_pc", if_pc_o, 32'hFFFF_FFFC);
    chk("wrap_head_instr", if_instr_o, 32'h77);
    step();
    chk("wrap_addr4", ic_addr_o, 32'h4);

    // Reset in the middle of a stall.
    ic_stall_i = 1'b1;
    step();
    chk("pre_rst_hold", ic_addr_o, 32'h4);
    rst_n = 1'b0;
    step();
    chk("mid_rst_req", 32'(ic_req_o), 32'd0);
    chk("mid_rst_valid", 32'(if_valid_o), 32'd0);
    chk("mid_rst_pc", if_pc_o, 32'h0);
    rst_n = 1'b1; ic_stall_i = 1'b0;
    step();
    chk("restart_req", 32'(ic_req_o), 32'd1);
    chk("restart_addr", ic_addr_o, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
